// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch bus: single-outstanding request/acknowledge.
// Latency: none (wires only); the memory may answer in the request cycle or later.
// Backpressure: the memory holds off by keeping imem_ack low; the fetch side keeps the request up.
//
// Signals:
//   imem_req   - fetch request, driven by the fetch stage
//   imem_addr  - fetch address (word address in bytes)
//   imem_ack   - response valid, driven by memory
//   imem_rdata - instruction word, meaningful only while imem_ack=1
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Fetch stage plus IF/ID register: holds PC_F, fetches through a single-outstanding imem handshake.
// Latency: a word reaches ir_d on the edge consuming its ack, or on the edge the ID stall releases.
// Backpressure: stall_d freezes PC_F and IF/ID; a word acked during a stall is parked in a skid register.
//
// Ports:
//   clk, reset     - core clock; synchronous active-high reset
//   next_pc        - selected next PC, sampled only on advancing edges
//   stall_d        - ID stall from the hazard unit
//   pc_add4        - PC_F + 4 (combinational) for the next-PC mux
//   pc_f           - current fetch PC
//   imem           - instruction-memory bus (master side)
//   ir_d/pc_d/pc8_d/valid_d - IF/ID register: instruction, its PC, link value PC+8, valid
//   adel_d         - address-error flag for a misaligned fetch (only with FETCH_ALIGN_CHECK_EN)
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned-PC detection, adds adel_d).
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        stall_d,
  output logic [31:0] pc_add4,
  output logic [31:0] pc_f,
  if_fetch_stage_if.master imem,
  output logic [31:0] ir_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        adel_d
`endif
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] skid;
  logic [31:0] pc_f8;

  assign pc_add4 = pc_f + 32'd4;
  assign pc_f8   = pc_f + 32'd8;

  // No request while parked in S_HOLD: the skid already holds the word for pc_f.
`ifdef FETCH_ALIGN_CHECK_EN
  assign imem.imem_req = (state == S_FETCH) && !reset && (pc_f[1:0] == 2'b00);
`else
  assign imem.imem_req = (state == S_FETCH) && !reset;
`endif
  assign imem.imem_addr = pc_f;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      pc_f    <= RESET_PC;
      ir_d    <= NOP_INSTR;
      pc_d    <= 32'd0;
      pc8_d   <= 32'd0;
      valid_d <= 1'b0;
      skid    <= 32'd0;
`ifdef FETCH_ALIGN_CHECK_EN
      adel_d  <= 1'b0;
`endif
    end else begin
      case (state)
        S_FETCH: begin
`ifdef FETCH_ALIGN_CHECK_EN
          // Misaligned PC: never reaches memory; a valid NOP carrying the
          // error flag moves into ID so the exception is taken there.
          if (pc_f[1:0] != 2'b00) begin
            if (!stall_d) begin
              ir_d    <= NOP_INSTR;
              pc_d    <= pc_f;
              pc8_d   <= pc_f8;
              valid_d <= 1'b1;
              adel_d  <= 1'b1;
              pc_f    <= next_pc;
            end
          end else
`endif
          if (imem.imem_ack) begin
            if (!stall_d) begin
              ir_d    <= imem.imem_rdata;
              pc_d    <= pc_f;
              pc8_d   <= pc_f8;
              valid_d <= 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
              adel_d  <= 1'b0;
`endif
              pc_f    <= next_pc;
            end else begin
              // ID cannot take the word yet; park it and stop requesting.
              skid  <= imem.imem_rdata;
              state <= S_HOLD;
            end
          end else if (!stall_d) begin
            // Memory still busy: push a bubble, keep pc_d/pc8_d of the last real one.
            ir_d    <= NOP_INSTR;
            valid_d <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall_d) begin
            ir_d    <= skid;
            pc_d    <= pc_f;
            pc8_d   <= pc_f8;
            valid_d <= 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
            adel_d  <= 1'b0;
`endif
            pc_f    <= next_pc;
            state   <= S_FETCH;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall_d;
  logic        ack;
  logic        use_add4;
  logic [31:0] next_ovr;
  logic [31:0] next_pc;
  logic [31:0] pc_add4, pc_f, ir_d, pc_d, pc8_d;
  logic        valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        adel_d;
`endif
  int checks = 0;
  int errors = 0;

  if_fetch_stage_if bus ();

  // Memory returns word = address; ack timing is driven directly by the bench.
  assign bus.imem_rdata = bus.imem_addr;
  assign bus.imem_ack   = ack;
  assign next_pc        = use_add4 ? pc_add4 : next_ovr;

  if_fetch_stage dut (
    .clk     (clk),
    .reset   (reset),
    .next_pc (next_pc),
    .stall_d (stall_d),
    .pc_add4 (pc_add4),
    .pc_f    (pc_f),
    .imem    (bus.master),
    .ir_d    (ir_d),
    .pc_d    (pc_d),
    .pc8_d   (pc8_d),
    .valid_d (valid_d)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .adel_d  (adel_d)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall_d = 1'b0; ack = 1'b0; use_add4 = 1'b1; next_ovr = 32'd0;
    tick(); tick();
    checks++; if (pc_f !== 32'h0000_3000) begin errors++; $display("FAIL rst_pc_f got %h exp 00003000", pc_f); end
    checks++; if (ir_d !== 32'h0) begin errors++; $display("FAIL rst_ir_d got %h exp 00000000", ir_d); end
    checks++; if (pc_d !== 32'h0 || pc8_d !== 32'h0) begin errors++; $display("FAIL rst_pc_d got %h/%h exp 0/0", pc_d, pc8_d); end
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", valid_d); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", bus.imem_req); end
    reset = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_3000) begin errors++; $display("FAIL first_req got %b/%h exp 1/00003000", bus.imem_req, bus.imem_addr); end
    checks++; if (pc_add4 !== 32'h0000_3004) begin errors++; $display("FAIL pc_add4 got %h exp 00003004", pc_add4); end
  endtask

  task automatic test_zero_wait();
    ack = 1'b1;
    tick();
    checks++; if (ir_d !== 32'h0000_3000 || pc_d !== 32'h0000_3000) begin errors++; $display("FAIL zw_ir got %h/%h exp 00003000/00003000", ir_d, pc_d); end
    checks++; if (pc8_d !== 32'h0000_3008 || valid_d !== 1'b1) begin errors++; $display("FAIL zw_pc8 got %h/%b exp 00003008/1", pc8_d, valid_d); end
    checks++; if (pc_f !== 32'h0000_3004) begin errors++; $display("FAIL zw_pc_f got %h exp 00003004", pc_f); end
  endtask

  task automatic test_wait_states();
    ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (ir_d !== 32'h0 || valid_d !== 1'b0) begin errors++; $display("FAIL bubble%0d got %h/%b exp 00000000/0", i, ir_d, valid_d); end
      checks++; if (pc_d !== 32'h0000_3000 || pc_f !== 32'h0000_3004) begin errors++; $display("FAIL bubble_hold%0d got pc_d %h pc_f %h exp 00003000/00003004", i, pc_d, pc_f); end
    end
    ack = 1'b1;
    tick();
    checks++; if (ir_d !== 32'h0000_3004 || pc_d !== 32'h0000_3004 || pc8_d !== 32'h0000_300C) begin errors++; $display("FAIL late_ack got %h/%h/%h exp 00003004/00003004/0000300c", ir_d, pc_d, pc8_d); end
    checks++; if (pc_f !== 32'h0000_3008 || valid_d !== 1'b1) begin errors++; $display("FAIL late_pc_f got %h/%b exp 00003008/1", pc_f, valid_d); end
  endtask

  task automatic test_stall_skid();
    ack = 1'b1; stall_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL hold_req%0d got %b exp 0", i, bus.imem_req); end
      checks++; if (ir_d !== 32'h0000_3004 || pc_f !== 32'h0000_3008 || valid_d !== 1'b1) begin errors++; $display("FAIL hold_if_id%0d got %h/%h/%b exp 00003004/00003008/1", i, ir_d, pc_f, valid_d); end
    end
    stall_d = 1'b0; ack = 1'b0;
    tick();
    checks++; if (ir_d !== 32'h0000_3008 || pc_d !== 32'h0000_3008 || pc8_d !== 32'h0000_3010) begin errors++; $display("FAIL skid_rel got %h/%h/%h exp 00003008/00003008/00003010", ir_d, pc_d, pc8_d); end
    checks++; if (pc_f !== 32'h0000_300C || bus.imem_req !== 1'b1) begin errors++; $display("FAIL skid_pc_f got %h/%b exp 0000300c/1", pc_f, bus.imem_req); end
  endtask

  task automatic test_jump();
    ack = 1'b1; use_add4 = 1'b0; next_ovr = 32'h0000_4000;
    tick();
    checks++; if (ir_d !== 32'h0000_300C || pc_f !== 32'h0000_4000) begin errors++; $display("FAIL jmp_slot got %h/%h exp 0000300c/00004000", ir_d, pc_f); end
    checks++; if (bus.imem_addr !== 32'h0000_4000) begin errors++; $display("FAIL jmp_addr got %h exp 00004000", bus.imem_addr); end
    use_add4 = 1'b1;
    tick();
    checks++; if (ir_d !== 32'h0000_4000 || pc_d !== 32'h0000_4000 || pc_f !== 32'h0000_4004) begin errors++; $display("FAIL jmp_tgt got %h/%h/%h exp 00004000/00004000/00004004", ir_d, pc_d, pc_f); end
  endtask

  task automatic test_wrap();
    use_add4 = 1'b0; next_ovr = 32'hFFFF_FFFC;
    tick();
    use_add4 = 1'b1;
    #1;
    checks++; if (pc_f !== 32'hFFFF_FFFC || pc_add4 !== 32'h0) begin errors++; $display("FAIL wrap_add4 got %h/%h exp fffffffc/00000000", pc_f, pc_add4); end
    tick();
    checks++; if (pc_d !== 32'hFFFF_FFFC || pc8_d !== 32'h0000_0004 || pc_f !== 32'h0) begin errors++; $display("FAIL wrap_pc8 got %h/%h/%h exp fffffffc/00000004/00000000", pc_d, pc8_d, pc_f); end
  endtask

  task automatic test_reset_in_hold();
    ack = 1'b1; stall_d = 1'b1;
    tick();
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL pre_rst_hold got %b exp 0", bus.imem_req); end
    reset = 1'b1;
    tick();
    checks++; if (pc_f !== 32'h0000_3000 || valid_d !== 1'b0 || ir_d !== 32'h0) begin errors++; $display("FAIL hold_rst got %h/%b/%h exp 00003000/0/00000000", pc_f, valid_d, ir_d); end
    reset = 1'b0; stall_d = 1'b0; ack = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_3000) begin errors++; $display("FAIL post_rst_req got %b/%h exp 1/00003000", bus.imem_req, bus.imem_addr); end
    ack = 1'b1;
    tick();
    checks++; if (ir_d !== 32'h0000_3000 || valid_d !== 1'b1 || pc_f !== 32'h0000_3004) begin errors++; $display("FAIL post_rst_fetch got %h/%b/%h exp 00003000/1/00003004", ir_d, valid_d, pc_f); end
  endtask

  task automatic test_stall_no_ack();
    ack = 1'b0; stall_d = 1'b1;
    tick(); tick();
    checks++; if (ir_d !== 32'h0000_3000 || valid_d !== 1'b1 || pc_f !== 32'h0000_3004) begin errors++; $display("FAIL stall_idle got %h/%b/%h exp 00003000/1/00003004", ir_d, valid_d, pc_f); end
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL stall_idle_req got %b exp 1", bus.imem_req); end
    stall_d = 1'b0;
  endtask

`ifdef FETCH_ALIGN_CHECK_EN
  task automatic test_align();
    reset = 1'b1; ack = 1'b0; stall_d = 1'b0; use_add4 = 1'b1;
    tick();
    reset = 1'b0; ack = 1'b1; use_add4 = 1'b0; next_ovr = 32'h0000_3002;
    tick();
    use_add4 = 1'b1;
    #1;
    checks++; if (pc_f !== 32'h0000_3002 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL mis_req got %h/%b exp 00003002/0", pc_f, bus.imem_req); end
    checks++; if (adel_d !== 1'b0) begin errors++; $display("FAIL adel_pre got %b exp 0", adel_d); end
    tick();
    checks++; if (adel_d !== 1'b1 || ir_d !== 32'h0 || valid_d !== 1'b1) begin errors++; $display("FAIL adel got %b/%h/%b exp 1/00000000/1", adel_d, ir_d, valid_d); end
    checks++; if (pc_d !== 32'h0000_3002 || pc8_d !== 32'h0000_300A || pc_f !== 32'h0000_3006) begin errors++; $display("FAIL adel_pc got %h/%h/%h exp 00003002/0000300a/00003006", pc_d, pc8_d, pc_f); end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall_skid();
    test_jump();
    test_wrap();
    test_reset_in_hold();
    test_stall_no_ack();
`ifdef FETCH_ALIGN_CHECK_EN
    test_align();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
